// File: rtl/completion_writeback_pkg.sv
// Shared definitions for the completion/writeback slice: functional-unit codes
// and the round-robin successor used by the retirement arbiter.
package completion_writeback_pkg;

    typedef enum logic [1:0] {
        FU_ALUMISC = 2'b00,
        FU_MEM     = 2'b01,
        FU_MULT    = 2'b10,
        FU_NONE    = 2'b11
    } unit_e;

    localparam int unsigned NUM_UNITS = 3;

    function automatic unit_e next_unit(input unit_e u);
        case (u)
            FU_ALUMISC: return FU_MEM;
            FU_MEM:     return FU_MULT;
            default:    return FU_ALUMISC;
        endcase
    endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Per-unit synchronous result FIFO; head is the oldest entry, full/empty derive
// from registered occupancy only.
module wb_result_fifo #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned WIDTH      = 38
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PW+1)'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/completion_writeback.sv
// Retirement stage: buffers AluMisc/Mem/Mult results, round-robin retires one
// per cycle onto the ARF write port and issues the matching scoreboard clear.
module completion_writeback
    import completion_writeback_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  am_wb_valid,
    input  logic [ADDR_WIDTH-1:0] am_wb_regdest,
    input  logic                  am_wb_writereg,
    input  logic [DATA_WIDTH-1:0] am_wb_data,
    output logic                  am_wb_ready,
    input  logic                  mem_wb_valid,
    input  logic [ADDR_WIDTH-1:0] mem_wb_regdest,
    input  logic                  mem_wb_writereg,
    input  logic [DATA_WIDTH-1:0] mem_wb_data,
    output logic                  mem_wb_ready,
    input  logic                  mul_wb_valid,
    input  logic [ADDR_WIDTH-1:0] mul_wb_regdest,
    input  logic                  mul_wb_writereg,
    input  logic [DATA_WIDTH-1:0] mul_wb_data,
    output logic                  mul_wb_ready,
    output logic                  wb_reg_writeenable,
    output logic [ADDR_WIDTH-1:0] wb_reg_writeaddr,
    output logic [DATA_WIDTH-1:0] wb_reg_writedata,
    output logic                  wb_sb_clear,
    output logic [ADDR_WIDTH-1:0] wb_sb_clearaddr,
    output logic [1:0]            wb_sb_clearunit,
    output logic [31:0]           wb_retired_count
);

    localparam int unsigned EW = 1 + ADDR_WIDTH + DATA_WIDTH;

    logic [EW-1:0]         push_e [NUM_UNITS];
    logic [EW-1:0]         head_e [NUM_UNITS];
    logic [NUM_UNITS-1:0]  push_v;
    logic [NUM_UNITS-1:0]  pop_v;
    logic [NUM_UNITS-1:0]  full_v;
    logic [NUM_UNITS-1:0]  empty_v;

    unit_e                 rr;
    unit_e                 cand;
    unit_e                 grant_unit;
    logic                  grant_found;
    logic [EW-1:0]         g_head;
    logic                  g_wr;
    logic [ADDR_WIDTH-1:0] g_dest;
    logic [DATA_WIDTH-1:0] g_data;

    unit_e                 clear_unit_q;
    logic [31:0]           retired_q;

    assign push_e[0] = {am_wb_writereg,  am_wb_regdest,  am_wb_data};
    assign push_e[1] = {mem_wb_writereg, mem_wb_regdest, mem_wb_data};
    assign push_e[2] = {mul_wb_writereg, mul_wb_regdest, mul_wb_data};
    assign push_v    = {mul_wb_valid, mem_wb_valid, am_wb_valid};

    assign am_wb_ready  = !full_v[0];
    assign mem_wb_ready = !full_v[1];
    assign mul_wb_ready = !full_v[2];

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_fifo
        wb_result_fifo #(
            .FIFO_DEPTH (FIFO_DEPTH),
            .WIDTH      (EW)
        ) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .push      (push_v[u]),
            .push_data (push_e[u]),
            .pop       (pop_v[u]),
            .head      (head_e[u]),
            .full      (full_v[u]),
            .empty     (empty_v[u])
        );
    end

    // rr holds the unit with highest priority this cycle (one past the last grant)
    always_comb begin
        grant_found = 1'b0;
        grant_unit  = FU_NONE;
        cand        = rr;
        pop_v       = '0;
        g_head      = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            if (!grant_found && !empty_v[cand]) begin
                grant_found = 1'b1;
                grant_unit  = cand;
            end
            cand = next_unit(cand);
        end
        if (grant_found) begin
            pop_v[grant_unit] = 1'b1;
            g_head            = head_e[grant_unit];
        end
    end

    assign g_wr   = g_head[EW-1];
    assign g_dest = g_head[DATA_WIDTH +: ADDR_WIDTH];
    assign g_data = g_head[DATA_WIDTH-1:0];

    always_ff @(posedge clock) begin
        if (!reset) begin
            rr                 <= FU_ALUMISC;
            wb_reg_writeenable <= 1'b0;
            wb_reg_writeaddr   <= '0;
            wb_reg_writedata   <= '0;
            wb_sb_clear        <= 1'b0;
            wb_sb_clearaddr    <= '0;
            clear_unit_q       <= FU_NONE;
            retired_q          <= '0;
        end else begin
            wb_reg_writeenable <= 1'b0;
            wb_sb_clear        <= 1'b0;
            clear_unit_q       <= FU_NONE;
            if (grant_found) begin
                rr               <= next_unit(grant_unit);
                wb_reg_writeaddr <= g_dest;
                wb_reg_writedata <= g_data;
                wb_sb_clearaddr  <= g_dest;
                // stores take the slot but retire silently; x0 still clears
                if (g_wr) begin
                    wb_sb_clear        <= 1'b1;
                    clear_unit_q       <= grant_unit;
                    wb_reg_writeenable <= (g_dest != '0);
                    retired_q          <= retired_q + 32'd1;
                end
            end
        end
    end

    assign wb_sb_clearunit  = clear_unit_q;
    assign wb_retired_count = retired_q;

endmodule
